// File: rtl/dump_pkg.sv
// Shared beat tags, FSM states and header defaults for the CPU state dumper.
package dump_pkg;

  localparam logic [1:0] TAG_HDR_PC = 2'd0;
  localparam logic [1:0] TAG_REG    = 2'd1;
  localparam logic [1:0] TAG_MEM    = 2'd2;
  localparam logic [1:0] TAG_SUM    = 2'd3;

  localparam logic [15:0] DEF_HDR_MAGIC = 16'hD0D0;

  // Each non-idle state names the kind of beat currently held in the output register.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PC,
    S_REG,
    S_MEM,
    S_SUM
  } state_t;

endpackage

// File: rtl/dump_tx_reg.sv
// Valid/ready output register for the dump stream; loads whenever empty or the held beat is taken.
// Latency 1 cycle from load to presentation; holds payload stable while stalled.
module dump_tx_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_tag,
  input  logic              in_last,
  output logic              load,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        tag,
  output logic              last
);

  assign load = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      tag   <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      data  <= in_data;
      tag   <= in_tag;
      last  <= in_last;
    end
  end

endmodule

// File: rtl/cpu_state_dumper.sv
// Streams header, PC, register file, data memory and an XOR checksum as one handshaked frame.
// Header appears one cycle after the request; bubble-free under ready, fully stalls on !ready.
module cpu_state_dumper
  import dump_pkg::*;
#(
  parameter int          NUM_REGS  = 32,
  parameter int          NUM_MEM   = 32,
  parameter int          DATA_W    = 32,
  parameter logic [15:0] HDR_MAGIC = DEF_HDR_MAGIC
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        dump_req_i,
  input  logic [DATA_W-1:0]           pc_i,
  output logic [$clog2(NUM_REGS)-1:0] reg_addr_o,
  input  logic [DATA_W-1:0]           reg_data_i,
  output logic [$clog2(NUM_MEM)-1:0]  mem_addr_o,
  input  logic [DATA_W-1:0]           mem_data_i,
  output logic                        tx_valid_o,
  output logic [DATA_W-1:0]           tx_data_o,
  output logic [1:0]                  tx_tag_o,
  output logic                        tx_last_o,
  input  logic                        tx_ready_i,
  output logic                        busy_o
);

  localparam int RAW = $clog2(NUM_REGS);
  localparam int MAW = $clog2(NUM_MEM);
  localparam int KW  = (RAW > MAW) ? RAW : MAW;

  localparam logic [KW-1:0] REG_LAST = KW'(NUM_REGS - 1);
  localparam logic [KW-1:0] MEM_LAST = KW'(NUM_MEM - 1);

  state_t            state, state_nxt;
  logic [KW-1:0]     k, k_nxt, k_inc;
  logic [15:0]       seq;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] pc_snap;
  logic [DATA_W-1:0] hdr_word;

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic [1:0]        ld_tag;
  logic              ld_last;
  logic              load;
  logic              fire;

  assign fire     = tx_valid_o && tx_ready_i;
  assign k_inc    = k + KW'(1);
  assign hdr_word = DATA_W'({HDR_MAGIC, seq});
  assign busy_o   = (state != S_IDLE);

  // k indexes the beat on the wire, so the read ports look one entry ahead.
  assign reg_addr_o = (state == S_REG) ? k_inc[RAW-1:0] : '0;
  assign mem_addr_o = (state == S_MEM) ? k_inc[MAW-1:0] : '0;

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_tag    = TAG_HDR_PC;
    ld_last   = 1'b0;
    case (state)
      S_IDLE: begin
        if (dump_req_i) begin
          state_nxt = S_HDR;
          ld_valid  = 1'b1;
          ld_data   = hdr_word;
        end
      end
      S_HDR: begin
        if (fire) begin
          state_nxt = S_PC;
          ld_valid  = 1'b1;
          ld_data   = pc_snap;
        end
      end
      S_PC: begin
        if (fire) begin
          state_nxt = S_REG;
          k_nxt     = '0;
          ld_valid  = 1'b1;
          ld_data   = reg_data_i;
          ld_tag    = TAG_REG;
        end
      end
      S_REG: begin
        if (fire) begin
          ld_valid = 1'b1;
          if (k == REG_LAST) begin
            state_nxt = S_MEM;
            k_nxt     = '0;
            ld_data   = mem_data_i;
            ld_tag    = TAG_MEM;
          end else begin
            k_nxt   = k_inc;
            ld_data = reg_data_i;
            ld_tag  = TAG_REG;
          end
        end
      end
      S_MEM: begin
        if (fire) begin
          ld_valid = 1'b1;
          if (k == MEM_LAST) begin
            state_nxt = S_SUM;
            k_nxt     = '0;
            ld_data   = acc;
            ld_tag    = TAG_SUM;
            ld_last   = 1'b1;
          end else begin
            k_nxt   = k_inc;
            ld_data = mem_data_i;
            ld_tag  = TAG_MEM;
          end
        end
      end
      S_SUM: begin
        if (fire) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      k       <= '0;
      seq     <= '0;
      acc     <= '0;
      pc_snap <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (state == S_IDLE && dump_req_i) begin
        pc_snap <= pc_i;
      end
      // Header restarts the running XOR; loading the checksum itself leaves it at zero.
      if (load && ld_valid) begin
        acc <= (state == S_IDLE) ? ld_data : (acc ^ ld_data);
      end
      if (fire && state == S_SUM) begin
        seq <= seq + 16'd1;
      end
    end
  end

  dump_tx_reg #(
    .DATA_W(DATA_W)
  ) u_tx_reg (
    .clk      (clk_i),
    .rst      (rst_i),
    .in_valid (ld_valid),
    .in_data  (ld_data),
    .in_tag   (ld_tag),
    .in_last  (ld_last),
    .load     (load),
    .ready    (tx_ready_i),
    .valid    (tx_valid_o),
    .data     (tx_data_o),
    .tag      (tx_tag_o),
    .last     (tx_last_o)
  );

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Self-checking bench: directed frames with random data and backpressure against a frame-level model.
module tb_cpu_state_dumper;

  logic        clk;
  logic        rst_i;
  logic        dump_req_i;
  logic [31:0] pc_i;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_i;
  logic [4:0]  mem_addr_o;
  logic [31:0] mem_data_i;
  logic        tx_valid_o;
  logic [31:0] tx_data_o;
  logic [1:0]  tx_tag_o;
  logic        tx_last_o;
  logic        tx_ready_i;
  logic        busy_o;

  logic [31:0] rf [32];
  logic [31:0] dm [32];

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_seq;
  logic [31:0] exp_pc;
  logic [31:0] exp_d [$];
  logic [1:0]  exp_t [$];
  logic        exp_l [$];
  logic [31:0] got_d [$];
  logic [1:0]  got_t [$];
  logic        got_l [$];
  int          last_cycles;

  assign reg_data_i = rf[reg_addr_o];
  assign mem_data_i = dm[mem_addr_o];

  cpu_state_dumper dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .dump_req_i (dump_req_i),
    .pc_i       (pc_i),
    .reg_addr_o (reg_addr_o),
    .reg_data_i (reg_data_i),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_tag_o   (tx_tag_o),
    .tx_last_o  (tx_last_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Expected frame: header, snapshot PC, every register, every memory word, then XOR of all of them.
  task automatic build_expected();
    logic [31:0] x;
    exp_d.delete(); exp_t.delete(); exp_l.delete();
    exp_d.push_back({16'hD0D0, exp_seq}); exp_t.push_back(2'd0); exp_l.push_back(1'b0);
    exp_d.push_back(exp_pc);              exp_t.push_back(2'd0); exp_l.push_back(1'b0);
    for (int i = 0; i < 32; i++) begin
      exp_d.push_back(rf[i]); exp_t.push_back(2'd1); exp_l.push_back(1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      exp_d.push_back(dm[i]); exp_t.push_back(2'd2); exp_l.push_back(1'b0);
    end
    x = 32'h0;
    foreach (exp_d[i]) x = x ^ exp_d[i];
    exp_d.push_back(x); exp_t.push_back(2'd3); exp_l.push_back(1'b1);
  endtask

  // Called at a negedge with the request already set; returns at the negedge after the header edge.
  task automatic start_frame(input string nm, input logic [31:0] pc_val, input bit hold);
    exp_pc     = pc_val;
    pc_i       = pc_val;
    dump_req_i = 1'b1;
    @(negedge clk);
    if (!hold) dump_req_i = 1'b0;
    chk({nm, "_hdr_valid"}, 32'(tx_valid_o), 32'd1);
    chk({nm, "_hdr_busy"},  32'(busy_o),     32'd1);
    chk({nm, "_hdr_data"},  tx_data_o,       {16'hD0D0, exp_seq});
  endtask

  // Drives ready with the given percentage and records accepted beats until the last one.
  task automatic collect(input string nm, input int pct);
    int          cyc;
    int          stall_bad;
    bit          done;
    bit          held;
    logic [31:0] hd;
    logic [1:0]  ht;
    logic        hl;
    cyc = 0; stall_bad = 0; done = 0; held = 0;
    hd = '0; ht = '0; hl = 1'b0;
    got_d.delete(); got_t.delete(); got_l.delete();
    while (!done && cyc < 2000) begin
      if (held && (!tx_valid_o || tx_data_o !== hd || tx_tag_o !== ht || tx_last_o !== hl))
        stall_bad++;
      tx_ready_i = ($urandom_range(99) < pct);
      held = 1'b0;
      if (tx_valid_o && tx_ready_i) begin
        got_d.push_back(tx_data_o); got_t.push_back(tx_tag_o); got_l.push_back(tx_last_o);
        if (tx_last_o) done = 1;
      end else if (tx_valid_o) begin
        held = 1'b1; hd = tx_data_o; ht = tx_tag_o; hl = tx_last_o;
      end
      cyc++;
      if (!done) @(negedge clk);
    end
    last_cycles = cyc;
    chk({nm, "_frame_done"},   32'(done),      32'd1);
    chk({nm, "_stall_stable"}, 32'(stall_bad), 32'd0);
  endtask

  task automatic compare_frame(input string nm);
    int n;
    build_expected();
    chk({nm, "_beat_count"}, 32'(got_d.size()), 32'(exp_d.size()));
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", nm, i), got_d[i], exp_d[i]);
      chk($sformatf("%s_tag%0d", nm, i),  32'(got_t[i]), 32'(exp_t[i]));
      chk($sformatf("%s_last%0d", nm, i), 32'(got_l[i]), 32'(exp_l[i]));
    end
    exp_seq = exp_seq + 16'd1;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_valid"}, 32'(tx_valid_o), 32'd0);
    chk({nm, "_busy"},  32'(busy_o),     32'd0);
  endtask

  initial begin
    int guard;
    rst_i = 1'b1; dump_req_i = 1'b0; pc_i = '0; tx_ready_i = 1'b0;
    exp_seq = 16'h0; exp_pc = '0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'(i * 3);
      dm[i] = 32'(100 + i);
    end
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_data",  tx_data_o,       32'd0);
    chk("rst_tag",   32'(tx_tag_o),   32'd0);
    chk("rst_last",  32'(tx_last_o),  32'd0);
    chk("rst_busy",  32'(busy_o),     32'd0);
    chk("rst_raddr", 32'(reg_addr_o), 32'd0);
    chk("rst_maddr", 32'(mem_addr_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check_idle("idle");

    // Frame with ready held high: 67 back-to-back beats.
    tx_ready_i = 1'b1;
    start_frame("f1", 32'h0000_0040, 1'b0);
    collect("f1", 100);
    chk("f1_cycles", 32'(last_cycles), 32'd67);
    compare_frame("f1");
    @(negedge clk);
    check_idle("f1_end");

    // Random backpressure; live PC changes after the request must not leak into the frame.
    start_frame("f2", 32'h0000_0040, 1'b0);
    pc_i = 32'hDEAD_BEEF;
    collect("f2", 50);
    compare_frame("f2");
    @(negedge clk);
    check_idle("f2_end");

    // Request held for the whole frame: only one frame, the next starts right after busy drops.
    pc_i = 32'h0000_1234;
    start_frame("f3", 32'h0000_1234, 1'b1);
    collect("f3", 70);
    compare_frame("f3");
    @(negedge clk);
    check_idle("f3_end");
    @(negedge clk);
    dump_req_i = 1'b0;
    chk("f4_hdr_valid", 32'(tx_valid_o), 32'd1);
    chk("f4_hdr_busy",  32'(busy_o),     32'd1);
    chk("f4_hdr_data",  tx_data_o,       {16'hD0D0, exp_seq});
    collect("f4", 60);
    compare_frame("f4");
    @(negedge clk);
    check_idle("f4_end");

    // Stall on the first memory beat.
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
      dm[i] = $urandom;
    end
    tx_ready_i = 1'b1;
    start_frame("f5", $urandom, 1'b0);
    guard = 0;
    while (!(tx_valid_o && tx_tag_o == 2'd2) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("f5_reach_mem", 32'(tx_tag_o), 32'd2);
    tx_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("f5_stall_maddr%0d", c), 32'(mem_addr_o), 32'd1);
      chk($sformatf("f5_stall_data%0d", c),  tx_data_o,       dm[0]);
      @(negedge clk);
    end
    tx_ready_i = 1'b1;
    guard = 0;
    while (!(tx_valid_o && tx_last_o) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("f5_reach_last", 32'(tx_last_o), 32'd1);
    exp_seq = exp_seq + 16'd1;
    @(negedge clk);
    check_idle("f5_end");

    // Reset mid-frame at beat 20 aborts without a trailer and clears the sequence counter.
    start_frame("f6", 32'h0000_0200, 1'b0);
    repeat (20) @(negedge clk);
    chk("f6_beat20_tag", 32'(tx_tag_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    check_idle("f6_rst");
    chk("f6_rst_last", 32'(tx_last_o), 32'd0);
    rst_i = 1'b0;
    exp_seq = 16'h0;
    @(negedge clk);
    check_idle("f6_after");

    start_frame("f7", $urandom, 1'b0);
    collect("f7", 50);
    compare_frame("f7");
    @(negedge clk);
    check_idle("f7_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
